prio_encoder_latched: RTL and testbench
=======================================

# prio_encoder_latched

Parametrised, registered priority encoder with sticky request capture, per-input masking and an acknowledge handshake. Generalises the cascaded 16-to-4 encoder to N inputs and keeps the enable-in, group-select and enable-out semantics. Output codes stay stable until the consumer acknowledges them. The block serves as the interrupt/request front end for downstream controllers.

## Interface
- N, 16, number of request inputs; power of two, 2..64
- W, localparam $clog2(N), code width
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- EI  in  1  enable in, active high; gates request capture and new grants
- I  in  N  request inputs, sampled each edge; level or single-cycle pulse
- MASK  in  N  1 = input excluded from selection; its pending bit is still captured
- ACK  in  1  consumer acknowledges the presented code
- L  out  W  registered code of the granted input
- GS  out  1  group select; 1 = L is valid
- EO  out  1  enable out, combinational: EI & ~GS & no unmasked pending bit
- PEND  out  N  pending-request register

## Operation
- Capture: at each edge with EI=1, PEND <= (PEND | I) minus any bit cleared by ACK. If ACK clears bit g and I[g]=1 at the same edge, the set wins and PEND[g] stays 1.
- With EI=0, I is ignored and PEND changes only through ACK clears.
- Candidate set C = PEND & ~MASK.
- Selection: pick the first set bit of C, searching downward from index TOP with wrap-around. TOP = N-1 unless rotation is compiled in (see Configuration).
- FSM with two states:
  - IDLE: GS=0. If EI=1 and C≠0, register L <= picked index and GS <= 1, then go to HOLD. Otherwise stay in IDLE.
  - HOLD: GS=1 and L frozen. Changes to MASK, I or EI do not alter L.
  - HOLD with ACK=1: clear PEND[L] (subject to the set-wins rule), GS <= 0, go to IDLE.
- ACK is ignored in IDLE.
- Cascade: connect EO of a higher-priority instance to EI of a lower one. EO=1 means "nothing to serve here".
- Reset: PEND=0, L=0, GS=0, state IDLE, TOP=N-1. EO then equals EI.
- Reset asserted mid-HOLD discards the grant and all pending bits at that edge.

## Timing
- Request latency: I[k]=1 at edge t sets PEND[k] after edge t. GS=1 and L=k appear after edge t+1, provided the FSM is in IDLE and k is the top candidate.
- ACK sampled at edge a (GS=1): GS=0 after edge a. The next grant appears after edge a+1 at the earliest.
- Maximum throughput is one grant per 2 cycles with ACK tied high.
- GS and L are registered. EO is combinational from EI, GS and PEND/MASK, with no path from I.

## Configuration
- PRIO_ENC_ROTATE_EN defined: rotating priority. On each ACK of code g, TOP <= (g-1) mod N, so g becomes lowest priority. TOP resets to N-1.
- PRIO_ENC_ROTATE_EN undefined: TOP is the constant N-1, giving fixed priority where the highest index wins (CD4532 ordering). No TOP register is built.

## Structure
- Shared package prio_enc_pkg holds:
  - FSM state encoding (S_IDLE, S_HOLD)
  - the N range limits
  - the clog2 helper used for W
- One sub-module: prio_pick. It is a combinational N-bit, W-bit-start, wrap-around highest-first picker that outputs an index and an any-bit flag. It is instantiated once, with its start input tied to TOP.

## Test plan
- Reset, N=16: hold RST=1 for 2 cycles with I=16'hFFFF. Release RST with I=0 → PEND=0, GS=0, L=0, EO=EI=1.
- Fixed priority: with I=16'h8081 pulsed for one cycle and ACK held high → grants L=15, 7, 0 on successive GS windows, every 2 cycles. Then EO=1 and PEND=0.
- Hold stability: grant L=5. In HOLD, set MASK[5]=1 and pulse I[12] → L stays 5 until ACK. The next grant is L=12.
- Set-wins collision: in HOLD with L=3, assert ACK and I[3] on the same edge → PEND[3] remains 1 and L=3 is re-granted 2 cycles later.
- EI gating / cascade: with EI=0, pulse I=16'h0010 → PEND unchanged, GS=0, EO=0. Then EI=1 with the request level held → L=4 after 2 edges.
- Rotation (PRIO_ENC_ROTATE_EN): hold I=16'h8001 and always ACK → grants alternate 15, 0, 15, 0. Without the macro, the same stimulus grants 15 repeatedly.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the latched priority encoder: FSM encoding,
// supported input-count range and the code-width helper.
package prio_enc_pkg;

    localparam int PRIO_N_MIN = 2;
    localparam int PRIO_N_MAX = 64;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    function automatic int prio_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_latched_pick.sv
// Combinational wrap-around picker: first set bit of req searching
// downward from start, with an any-bit flag.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N = 16,
    parameter int W = prio_clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] k;

    // Walk farthest-to-nearest so the last hit is the one closest to start.
    always_comb begin
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int d = N - 1; d >= 0; d--) begin
            k = start - W'(d);
            if (req[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_latched.sv
// Registered priority encoder with sticky capture, masking and ACK handshake.
// Define PRIO_ENC_ROTATE_EN for rotating priority; default is fixed, top wins.
module prio_encoder_latched
    import prio_enc_pkg::*;
#(
    parameter int N = 16,
    localparam int W = prio_clog2(N)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EI,
    input  logic [N-1:0] I,
    input  logic [N-1:0] MASK,
    input  logic         ACK,
    output logic [W-1:0] L,
    output logic         GS,
    output logic         EO,
    output logic [N-1:0] PEND
);

    logic [0:0]   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] l_q, l_d;
    logic [W-1:0] top;
    logic [N-1:0] cand;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         ack_fire;

    assign cand     = pend_q & ~MASK;
    assign ack_fire = (state_q == S_HOLD) && ACK;

`ifdef PRIO_ENC_ROTATE_EN
    logic [W-1:0] top_q, top_d;

    // The acknowledged code drops to lowest priority.
    always_comb begin
        top_d = top_q;
        if (ack_fire) begin
            top_d = l_q - W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            top_q <= W'(N - 1);
        end else begin
            top_q <= top_d;
        end
    end

    assign top = top_q;
`else
    assign top = W'(N - 1);
`endif

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (cand),
        .start (top),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Clear first, then OR in new requests so a same-edge set wins.
    always_comb begin
        pend_d  = pend_q;
        state_d = state_q;
        l_d     = l_q;
        if (ack_fire) begin
            pend_d[l_q] = 1'b0;
        end
        if (EI) begin
            pend_d = pend_d | I;
        end
        case (state_q)
            S_IDLE: begin
                if (EI && pick_any) begin
                    l_d     = pick_idx;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            l_q     <= l_d;
        end
    end

    assign L    = l_q;
    assign GS   = (state_q == S_HOLD);
    assign EO   = EI & ~GS & ~(|cand);
    assign PEND = pend_q;

endmodule

// File: tb/tb_prio_encoder_latched.sv
// Bench for prio_encoder_latched: reference model compared every cycle
// plus directed vectors with literal expectations.
module tb_prio_encoder_latched;

    localparam int N = 16;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EI;
    logic         ACK;
    logic [N-1:0] I;
    logic [N-1:0] MASK;
    logic [W-1:0] L;
    logic         GS;
    logic         EO;
    logic [N-1:0] PEND;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    prio_encoder_latched #(.N(N)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EI   (EI),
        .I    (I),
        .MASK (MASK),
        .ACK  (ACK),
        .L    (L),
        .GS   (GS),
        .EO   (EO),
        .PEND (PEND)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: pending requests as a bit list, grant as an integer.
    bit m_pend[N];
    int m_l    = 0;
    bit m_gs   = 0;
    int m_top  = N - 1;
    bit m_live = 0;

    function automatic int m_pick(input logic [N-1:0] msk);
        for (int d = 0; d < N; d++) begin
            int k;
            k = (m_top - d + N) % N;
            if (m_pend[k] && !msk[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k] = m_pend[k];
        return v;
    endfunction

    always @(posedge CLK) begin
        bit nxt[N];
        int p;
        if (RST) begin
            for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
            m_gs  = 1'b0;
            m_l   = 0;
            m_top = N - 1;
        end else begin
            nxt = m_pend;
            if (m_gs && ACK) begin
                nxt[m_l] = 1'b0;
                m_gs = 1'b0;
`ifdef PRIO_ENC_ROTATE_EN
                m_top = (m_l + N - 1) % N;
`endif
            end else if (!m_gs && EI) begin
                p = m_pick(MASK);
                if (p >= 0) begin
                    m_l  = p;
                    m_gs = 1'b1;
                end
            end
            if (EI) begin
                for (int k = 0; k < N; k++) if (I[k]) nxt[k] = 1'b1;
            end
            m_pend = nxt;
        end
        m_live = 1'b1;
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("model_pend", PEND, m_vec());
            chk("model_gs", GS, m_gs);
            chk("model_l", L, m_l);
            chk("model_eo", EO, EI && !m_gs && (m_pick(MASK) < 0));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    int rot_exp[4];

    initial begin
`ifdef PRIO_ENC_ROTATE_EN
        rot_exp = '{15, 0, 15, 0};
`else
        rot_exp = '{15, 15, 15, 15};
`endif
        RST = 1'b1; EI = 1'b1; I = '1; MASK = '0; ACK = 1'b0;
        cyc(2);
        RST = 1'b0; I = '0;
        look();
        chk("rst_pend", PEND, 16'h0000);
        chk("rst_gs", GS, 1'b0);
        chk("rst_l", L, 4'd0);
        chk("rst_eo", EO, 1'b1);

        // Fixed priority drain with ACK tied high
        I = 16'h8081; ACK = 1'b1;
        cyc();
        I = '0;
        cyc();
        look();
        chk("fix_l15", L, 4'd15);
        chk("fix_gs15", GS, 1'b1);
        cyc(2); look();
        chk("fix_l7", L, 4'd7);
        cyc(2); look();
        chk("fix_l0", L, 4'd0);
        cyc(); look();
        chk("fix_gs_end", GS, 1'b0);
        chk("fix_pend_end", PEND, 16'h0000);
        chk("fix_eo_end", EO, 1'b1);
        ACK = 1'b0;

        // Hold stability against MASK and new requests
        I = 16'h0020;
        cyc();
        I = '0;
        cyc(); look();
        chk("hold_l5", L, 4'd5);
        MASK = 16'h0020; I = 16'h1000;
        cyc();
        I = '0;
        cyc(); look();
        chk("hold_l5_frozen", L, 4'd5);
        chk("hold_gs", GS, 1'b1);
        chk("hold_pend", PEND, 16'h1020);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        look();
        chk("hold_ack_gs", GS, 1'b0);
        cyc(); look();
        chk("hold_next_l12", L, 4'd12);
        MASK = '0; ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        look();
        chk("hold_pend_end", PEND, 16'h0000);

        // Set wins over a same-edge ACK clear
        I = 16'h0008;
        cyc();
        I = '0;
        cyc(); look();
        chk("sw_l3", L, 4'd3);
        ACK = 1'b1; I = 16'h0008;
        cyc();
        ACK = 1'b0; I = '0;
        look();
        chk("sw_pend3", PEND, 16'h0008);
        chk("sw_gs0", GS, 1'b0);
        cyc(); look();
        chk("sw_regrant", L, 4'd3);
        chk("sw_regrant_gs", GS, 1'b1);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;

        // EI gating
        EI = 1'b0; I = 16'h0010;
        cyc();
        look();
        chk("ei_pend", PEND, 16'h0000);
        chk("ei_gs", GS, 1'b0);
        chk("ei_eo", EO, 1'b0);
        EI = 1'b1;
        cyc(2); look();
        chk("ei_l4", L, 4'd4);
        I = '0; ACK = 1'b1;
        cyc();
        ACK = 1'b0;

        // Masked pending bit is captured but never granted
        MASK = 16'h0040; I = 16'h0040;
        cyc();
        I = '0;
        cyc(); look();
        chk("mask_pend", PEND, 16'h0040);
        chk("mask_gs", GS, 1'b0);
        chk("mask_eo", EO, 1'b1);
        MASK = '0;
        cyc(); look();
        chk("mask_l6", L, 4'd6);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;

        // Rotation / fixed repeat with a held two-bit request
        I = 16'h8001; ACK = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc(); look();
            chk($sformatf("rot_l%0d", k), L, rot_exp[k]);
            cyc();
        end
        I = '0;
        cyc(4); look();
        chk("rot_pend_end", PEND, 16'h0000);
        chk("rot_gs_end", GS, 1'b0);
        ACK = 1'b0;

        // Reset in HOLD drops grant and pending bits
        I = 16'h0081;
        cyc();
        I = '0;
        cyc(); look();
        chk("mrst_l7", L, 4'd7);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        look();
        chk("mrst_pend", PEND, 16'h0000);
        chk("mrst_gs", GS, 1'b0);
        chk("mrst_l", L, 4'd0);
        cyc(2); look();
        chk("mrst_idle", GS, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
